regfile: RTL

- Y86 program-register file; the write-back end of the execute datapath.
- Sinks the execute stage's dstE/valE result and the memory stage's dstM/valM result.
- Sources valA/valB operands for decode/execute.
- Eight 32-bit architectural registers: %eax..%edi, IDs 0-7. ID 8'h0F (RNONE) means "no register".

---
 rtl/regfile_if.sv | 27 ++
 rtl/regfile.sv | 83 ++++++++
 2 files changed

// File: rtl/regfile_if.sv
// rtl/regfile_if.sv - write-back, read-port and debug bus of the Y86 register file
interface regfile_if #(
    parameter int WIDTH = 32
);
    logic             wr_en_i;
    logic [7:0]       dstE_i;
    logic [WIDTH-1:0] valE_i;
    logic [7:0]       dstM_i;
    logic [WIDTH-1:0] valM_i;
    logic [7:0]       srcA_i;
    logic [7:0]       srcB_i;
    logic [WIDTH-1:0] valA_o;
    logic [WIDTH-1:0] valB_o;
    logic [2:0]       dbg_sel_i;
    logic [WIDTH-1:0] dbg_val_o;
    logic             err_o;

    modport master (
        output wr_en_i, dstE_i, valE_i, dstM_i, valM_i, srcA_i, srcB_i, dbg_sel_i,
        input  valA_o, valB_o, dbg_val_o, err_o
    );

    modport slave (
        input  wr_en_i, dstE_i, valE_i, dstM_i, valM_i, srcA_i, srcB_i, dbg_sel_i,
        output valA_o, valB_o, dbg_val_o, err_o
    );
endinterface

// File: rtl/regfile.sv
// rtl/regfile.sv - Y86 register file with dual write-back, write-first bypass and sticky dst error
module regfile #(
    parameter int         NREGS = 8,
    parameter int         WIDTH = 32,
    parameter logic [7:0] RNONE = 8'h0F
) (
    input  logic     clk,
    input  logic     rst,
    regfile_if.slave bus
);
    logic [WIDTH-1:0] r_regs [NREGS];
    logic             r_err;

    logic             w_e_valid;
    logic             w_m_valid;
    logic             w_dst_bad;
    logic [WIDTH-1:0] w_val_a;
    logic [WIDTH-1:0] w_val_b;
    logic [WIDTH-1:0] w_dbg_val;

    assign w_e_valid = (bus.dstE_i < 8'(NREGS));
    assign w_m_valid = (bus.dstM_i < 8'(NREGS));
    assign w_dst_bad = (!w_e_valid && (bus.dstE_i != RNONE)) ||
                       (!w_m_valid && (bus.dstM_i != RNONE));

    // M port is checked first so popl %esp keeps the popped value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_err <= 1'b0;
        end else if (bus.wr_en_i) begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_m_valid && (bus.dstM_i == 8'(i))) begin
                    r_regs[i] <= bus.valM_i;
                end else if (w_e_valid && (bus.dstE_i == 8'(i))) begin
                    r_regs[i] <= bus.valE_i;
                end
            end
            if (w_dst_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    function automatic logic [WIDTH-1:0] read_port(input logic [7:0] src);
        logic [WIDTH-1:0] v;
        v = '0;
        if (!rst && (src < 8'(NREGS))) begin
            for (int i = 0; i < NREGS; i++) begin
                if (src == 8'(i)) begin
                    v = r_regs[i];
                end
            end
            if (bus.wr_en_i && w_m_valid && (src == bus.dstM_i)) begin
                v = bus.valM_i;
            end else if (bus.wr_en_i && w_e_valid && (src == bus.dstE_i)) begin
                v = bus.valE_i;
            end
        end
        return v;
    endfunction

    always_comb begin
        w_val_a = read_port(bus.srcA_i);
        w_val_b = read_port(bus.srcB_i);
    end

    always_comb begin
        w_dbg_val = '0;
        for (int i = 0; i < NREGS; i++) begin
            if ({29'd0, bus.dbg_sel_i} == 32'(i)) begin
                w_dbg_val = r_regs[i];
            end
        end
    end

    assign bus.valA_o    = w_val_a;
    assign bus.valB_o    = w_val_b;
    assign bus.dbg_val_o = w_dbg_val;
    assign bus.err_o     = r_err;
endmodule
